// File: rtl/kd_pkg.sv
// ---------------------------------------------------------------------------
// kd_pkg
// Shared definitions for the kd-tree sequencer: default tree geometry,
// derived widths, the sequencer state encoding and tree-index helpers.
// Ports: none (package).
// ---------------------------------------------------------------------------
package kd_pkg;

  localparam int DIM        = 3;
  localparam int DATA_RANGE = 255;
  localparam int DEPTH      = 3;
  localparam int MAX_PASSES = 16;

  localparam int DIM_SIZE  = $clog2(DATA_RANGE);
  localparam int AXIS_SIZE = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int N_NODES   = (1 << DEPTH) - 1;
  localparam int IDX_SIZE  = (N_NODES > 1) ? $clog2(N_NODES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SORT_EVEN = 3'd1,
    ST_SORT_ODD  = 3'd2,
    ST_CHECK     = 3'd3,
    ST_Q_DESCEND = 3'd4,
    ST_Q_RESULT  = 3'd5
  } state_t;

  // floor(log2(idx+1)): tree level of a node in a heap-ordered array
  function automatic int node_level(input int idx);
    int lvl;
    lvl = 0;
    for (int k = 1; k < 32; k++) begin
      if (((idx + 1) >> k) != 0) lvl = k;
    end
    return lvl;
  endfunction

  function automatic bit is_leaf(input int idx, input int n_nodes);
    return idx >= (n_nodes / 2);
  endfunction

endpackage

// File: rtl/kd_node_map.sv
// ---------------------------------------------------------------------------
// kd_node_map
// Constant per-node decode of the complete binary tree: which non-leaf nodes
// sit on even / odd levels, and the split axis of every node.
// Ports:
//   even_mask  out n_nodes            non-leaf nodes on even levels
//   odd_mask   out n_nodes            non-leaf nodes on odd levels
//   node_axis  out n_nodes*axis_size  axis of node i = level(i) % dim
// ---------------------------------------------------------------------------
module kd_node_map
  import kd_pkg::*;
#(
  parameter int depth = DEPTH,
  parameter int dim   = DIM,
  localparam int n_nodes   = (1 << depth) - 1,
  localparam int axis_size = (dim > 1) ? $clog2(dim) : 1
)(
  output logic [n_nodes-1:0]           even_mask,
  output logic [n_nodes-1:0]           odd_mask,
  output logic [n_nodes*axis_size-1:0] node_axis
);

  for (genvar gi = 0; gi < n_nodes; gi++) begin : g_node
    localparam int LVL  = node_level(gi);
    localparam bit LEAF = is_leaf(gi, n_nodes);
    // leaves have no children to compare-exchange with, so they never sort
    assign even_mask[gi] = !LEAF && ((LVL % 2) == 0);
    assign odd_mask[gi]  = !LEAF && ((LVL % 2) == 1);
    assign node_axis[gi*axis_size +: axis_size] = axis_size'(LVL % dim);
  end

endmodule

// File: rtl/kd_tree_sequencer.sv
// ---------------------------------------------------------------------------
// kd_tree_sequencer
// Drives an array of compare-exchange nodes: builds a kd-tree with
// alternating even/odd level sort sweeps, then answers single-point
// root-to-leaf queries.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    build request (IDLE only)
//   stable_vec/first_dir_vec per-node status from the CE array
//   point_valid/point_ready  query point handshake, point_in payload
//   node_en, sorting,
//   point_prop, node_axis    CE array control
//   point_out                registered query point
//   build_done/build_err     build outcome (levels)
//   result_valid/ready/idx   leaf reached by the descent
// ---------------------------------------------------------------------------
module kd_tree_sequencer
  import kd_pkg::*;
#(
  parameter int dim        = DIM,
  parameter int data_range = DATA_RANGE,
  parameter int depth      = DEPTH,
  parameter int max_passes = MAX_PASSES,
  localparam int n_nodes   = (1 << depth) - 1,
  localparam int dim_size  = $clog2(data_range),
  localparam int axis_size = (dim > 1) ? $clog2(dim) : 1,
  localparam int idx_size  = (n_nodes > 1) ? $clog2(n_nodes) : 1,
  localparam int pass_w    = $clog2(max_passes + 1)
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [n_nodes-1:0]            stable_vec,
  input  logic [n_nodes-1:0]            first_dir_vec,
  input  logic                          point_valid,
  output logic                          point_ready,
  input  logic [dim*dim_size-1:0]       point_in,
  output logic [n_nodes-1:0]            node_en,
  output logic                          sorting,
  output logic                          point_prop,
  output logic [n_nodes*axis_size-1:0]  node_axis,
  output logic [dim*dim_size-1:0]       point_out,
  output logic                          build_done,
  output logic                          build_err,
  output logic                          result_valid,
  output logic [idx_size-1:0]           result_idx,
  input  logic                          result_ready
);

  state_t                  r_state, w_state_next;
  logic [pass_w-1:0]       r_pass_cnt, w_pass_next;
  logic                    r_prev_stable, w_prev_stable_next;
  logic                    r_build_done, w_build_done_next;
  logic                    r_build_err, w_build_err_next;
  logic [idx_size-1:0]     r_idx, w_idx_next, w_child;
  logic [dim*dim_size-1:0] r_point, w_point_next;
  logic                    r_result_valid, w_result_valid_next;
  logic [idx_size-1:0]     r_result_idx, w_result_idx_next;
  logic [n_nodes-1:0]      w_even_mask, w_odd_mask;

  kd_node_map #(.depth(depth), .dim(dim)) u_node_map (
    .even_mask (w_even_mask),
    .odd_mask  (w_odd_mask),
    .node_axis (node_axis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pass_cnt     <= '0;
      r_prev_stable  <= 1'b0;
      r_build_done   <= 1'b0;
      r_build_err    <= 1'b0;
      r_idx          <= '0;
      r_point        <= '0;
      r_result_valid <= 1'b0;
      r_result_idx   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pass_cnt     <= w_pass_next;
      r_prev_stable  <= w_prev_stable_next;
      r_build_done   <= w_build_done_next;
      r_build_err    <= w_build_err_next;
      r_idx          <= w_idx_next;
      r_point        <= w_point_next;
      r_result_valid <= w_result_valid_next;
      r_result_idx   <= w_result_idx_next;
    end
  end

  // first_direction=1 steers the point to the left child
  assign w_child = first_dir_vec[r_idx] ? idx_size'(2 * int'(r_idx) + 1)
                                        : idx_size'(2 * int'(r_idx) + 2);

  always_comb begin
    w_state_next        = r_state;
    w_pass_next         = r_pass_cnt;
    w_prev_stable_next  = r_prev_stable;
    w_build_done_next   = r_build_done;
    w_build_err_next    = r_build_err;
    w_idx_next          = r_idx;
    w_point_next        = r_point;
    w_result_valid_next = r_result_valid;
    w_result_idx_next   = r_result_idx;
    node_en             = '0;
    sorting             = 1'b0;
    point_prop          = 1'b0;
    point_ready         = (r_state == ST_IDLE) && r_build_done && !start;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_build_done_next  = 1'b0;
          w_build_err_next   = 1'b0;
          w_pass_next        = '0;
          w_prev_stable_next = 1'b0;
          w_state_next       = ST_SORT_EVEN;
        end else if (point_valid && point_ready) begin
          w_point_next = point_in;
          w_idx_next   = '0;
          if (depth == 1) begin
            // the root is already a leaf
            w_result_valid_next = 1'b1;
            w_result_idx_next   = '0;
            w_state_next        = ST_Q_RESULT;
          end else begin
            w_state_next = ST_Q_DESCEND;
          end
        end
      end
      ST_SORT_EVEN: begin
        sorting      = 1'b1;
        node_en      = w_even_mask;
        w_state_next = ST_SORT_ODD;
      end
      ST_SORT_ODD: begin
        sorting      = 1'b1;
        node_en      = w_odd_mask;
        w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_pass_next        = r_pass_cnt + 1'b1;
        w_prev_stable_next = &stable_vec;
        // one stable check can be a transient; require two in a row
        if ((&stable_vec) && r_prev_stable) begin
          w_build_done_next = 1'b1;
          w_state_next      = ST_IDLE;
        end else if (w_pass_next == pass_w'(max_passes)) begin
          w_build_err_next = 1'b1;
          w_state_next     = ST_IDLE;
        end else begin
          w_state_next = ST_SORT_EVEN;
        end
      end
      ST_Q_DESCEND: begin
        point_prop          = 1'b1;
        node_en[r_idx]      = 1'b1;
        w_idx_next          = w_child;
        if (is_leaf(int'(w_child), n_nodes)) begin
          w_result_valid_next = 1'b1;
          w_result_idx_next   = w_child;
          w_state_next        = ST_Q_RESULT;
        end
      end
      ST_Q_RESULT: begin
        if (result_ready) begin
          w_result_valid_next = 1'b0;
          w_result_idx_next   = '0;
          w_state_next        = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign build_done   = r_build_done;
  assign build_err    = r_build_err;
  assign point_out    = r_point;
  assign result_valid = r_result_valid;
  assign result_idx   = r_result_idx;

endmodule
